// File: rtl/lsu_ctrl.sv
// Load/store sequencer from MEM stage to the 4 KB big-endian data memory; `LSU_MISALIGN_SPLIT_EN` enables byte-split misaligned accesses.
// Latency: aligned response in cycle 2, fault in cycle 1, split in cycle N+1 (N = 2 or 4 bytes).
// Backpressure: req_ready only in IDLE, one request in flight, req_valid ignored while busy.
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
`ifdef LSU_MISALIGN_SPLIT_EN
    , SPLIT = 2'd3
`endif
  } state_t;

  state_t      state;
  logic        write_q;
  logic [2:0]  size_m1;
  logic [12:0] end_addr;
  logic        f3_legal;
  logic        range_ok;
  logic        misal;
  logic        req_fault;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [1:0]  cnt;
  logic [1:0]  last;
  logic [1:0]  nxt;
  logic [1:0]  req_last;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [23:0] rbuf;
  logic        split_q;

  // Big-endian byte select: sel 0 is the least significant byte of the store data.
  function automatic logic [7:0] be_byte(input logic [31:0] wd, input logic [1:0] sel);
    case (sel)
      2'd0:    be_byte = wd[7:0];
      2'd1:    be_byte = wd[15:8];
      2'd2:    be_byte = wd[23:16];
      default: be_byte = wd[31:24];
    endcase
  endfunction

  assign nxt      = cnt + 2'd1;
  assign req_last = (req_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;
`endif

  always_comb begin
    size_m1 = 3'd0;
    case (req_funct3[1:0])
      2'b01:   size_m1 = 3'd1;
      2'b10:   size_m1 = 3'd3;
      default: size_m1 = 3'd0;
    endcase
    if (req_write)
      f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else
      f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                 (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end_addr = {1'b0, req_addr[11:0]} + {10'd0, size_m1};
    range_ok = (req_addr[31:12] == 20'd0) && !end_addr[12];
    misal    = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_SPLIT_EN
    req_fault = !f3_legal || !range_ok;
`else
    req_fault = !f3_legal || !range_ok || misal;
`endif
  end

  // Read data is only valid during RESP, so the load result is muxed straight from the memory port.
  always_comb begin
    resp_rdata = 32'd0;
    if (state == RESP && !resp_fault && !write_q) begin
`ifdef LSU_MISALIGN_SPLIT_EN
      if (split_q) begin
        case (funct3_q)
          3'b001:  resp_rdata = {{16{rbuf[7]}}, rbuf[7:0], mem_rdata[7:0]};
          3'b101:  resp_rdata = {16'd0, rbuf[7:0], mem_rdata[7:0]};
          default: resp_rdata = {rbuf[23:0], mem_rdata[7:0]};
        endcase
      end else begin
        resp_rdata = mem_rdata;
      end
`else
      resp_rdata = mem_rdata;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      write_q    <= 1'b0;
      mem_addr   <= 32'd0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_wdata  <= 32'd0;
      mem_funct3 <= 3'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
      cnt        <= 2'd0;
      last       <= 2'd0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rbuf       <= 24'd0;
      split_q    <= 1'b0;
`endif
    end else begin
      mem_addr   <= 32'd0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_wdata  <= 32'd0;
      mem_funct3 <= 3'd0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            write_q   <= req_write;
            if (req_fault) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
            end else if (misal) begin
              state      <= SPLIT;
              split_q    <= 1'b1;
              cnt        <= 2'd0;
              last       <= req_last;
              funct3_q   <= req_funct3;
              addr_q     <= req_addr;
              wdata_q    <= req_wdata;
              mem_addr   <= req_addr;
              mem_read   <= !req_write;
              mem_write  <= req_write;
              mem_funct3 <= req_write ? 3'b000 : 3'b100;
              mem_wdata  <= req_write ? {24'd0, be_byte(req_wdata, req_last)} : 32'd0;
`endif
            end else begin
              state      <= ACCESS;
              mem_addr   <= req_addr;
              mem_read   <= !req_write;
              mem_write  <= req_write;
              mem_wdata  <= req_wdata;
              mem_funct3 <= req_funct3;
            end
          end
        end
        ACCESS: begin
          state      <= RESP;
          resp_valid <= 1'b1;
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        SPLIT: begin
          // mem_rdata now holds the byte issued in the previous cycle.
          if (cnt != 2'd0 && !write_q)
            rbuf <= {rbuf[15:0], mem_rdata[7:0]};
          if (cnt == last) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end else begin
            cnt        <= nxt;
            mem_addr   <= addr_q + {30'd0, nxt};
            mem_read   <= !write_q;
            mem_write  <= write_q;
            mem_funct3 <= write_q ? 3'b000 : 3'b100;
            mem_wdata  <= write_q ? {24'd0, be_byte(wdata_q, last - nxt)} : 32'd0;
          end
        end
`endif
        RESP: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
          split_q   <= 1'b0;
`endif
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the pipeline MEM stage and the byte-addressed, big-endian, 4 KB data memory. It accepts one load or store request via a valid/ready handshake and drives the memory's addr/MemRead/MemWrite/WriteData/funct3 port. It waits out the memory's one-cycle registered read and returns the result with a one-cycle response pulse. It also rejects illegal requests and optionally splits misaligned accesses into byte sequences.

## Interface
- No parameters; memory depth fixed at 4096 bytes (addr[11:0]).
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept (IDLE only)
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V load/store funct3
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result, sign/zero-extended; 0 for stores/faults
- resp_fault  out  1  qualifies resp_valid; request rejected, no memory write done
- busy  out  1  stall to pipeline; high in every non-IDLE state
- mem_addr  out  32  to data memory
- mem_read  out  1  to data memory MemRead
- mem_write  out  1  to data memory MemWrite
- mem_wdata  out  32  to data memory WriteData
- mem_funct3  out  3  to data memory funct3
- mem_rdata  in  32  from data memory ReadData (valid the cycle after mem_read)

## Operation
- States: IDLE, ACCESS, SPLIT, RESP.
- Handshake: accept when req_valid && req_ready at rising edge; request fields registered; req_valid ignored outside IDLE.
- Legal funct3: loads 000/001/010/100/101; stores 000/001/010. Anything else -> fault.
- Range fault: req_addr[31:12] != 0, or addr + size - 1 > 0xFFF (size 1/2/4).
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- IDLE -> RESP (fault) | ACCESS (legal aligned) | SPLIT (legal misaligned, macro on).
- ACCESS: drive mem_addr = addr, mem_funct3 = funct3, mem_read = !write, mem_write = write, mem_wdata = wdata; one cycle -> RESP.
- SPLIT: N = 2 (half) or 4 (word) consecutive byte accesses, byte k at addr+k. Loads use funct3 100; stores use 000 with mem_wdata[7:0] = big-endian byte k (half: k0 = wdata[15:8]; word: k0 = wdata[31:24]). Load byte k is captured from mem_rdata[7:0] one cycle after issue. After byte N-1 -> RESP.
- RESP: resp_valid=1 for one cycle -> IDLE. Aligned load: resp_rdata = mem_rdata. Split load: bytes concatenated MSB-first, then sign-extended (001) or zero-extended (101).
- mem_read/mem_write high only in ACCESS/SPLIT; mem_addr/mem_wdata/mem_funct3 = 0 otherwise.

## Timing
- Handshake edge ends cycle 0.
- Aligned: ACCESS in cycle 1; RESP in cycle 2; req_ready back in cycle 3.
- Split: SPLIT cycles 1..N; RESP in cycle N+1.
- Fault: RESP in cycle 1; never any mem_read/mem_write.
- Throughput: one request per 3 cycles aligned; no overlap.
- Reset: while rst_n=0 at an edge, next state IDLE and all outputs 0, including req_ready. req_ready=1 from the first cycle after release. Reset mid-SPLIT aborts remaining bytes with no response; bytes already stored stay written.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined: misaligned legal accesses take SPLIT path as above.
- Undefined: SPLIT state is absent; misaligned accesses fault in cycle 1 with no memory access.

## Test plan
- Aligned word store 0xDEADBEEF to 0x010, then lw 0x010 -> mem_write in cycle 1 only; load resp_valid in cycle 2 with resp_rdata=0xDEADBEEF, resp_fault=0.
- Memory byte 0x020=0x80: lb -> 0xFFFFFF80; lbu -> 0x00000080; each 2 cycles latency.
- lw at 0x1000 and funct3=011 load -> resp_fault=1 in cycle 1, resp_rdata=0, mem_read never asserted.
- Macro on: sw 0x11223344 to 0x021 -> four byte writes 0x11,0x22,0x33,0x44 at 0x021..0x024 in cycles 1-4, resp cycle 5. lh 0x023 -> 0x00003344, resp cycle 3. Macro off: same sw -> fault, memory unchanged.
- rst_n low during split-store cycle 2 -> no resp_valid, mem_write 0 next cycle, req_ready=1 after release.
- req_valid held high continuously through busy -> exactly one accept per IDLE visit, busy high in all non-IDLE cycles.
